// File: rtl/tile_sched_pkg.sv
// Shared types and constants for the tiled matrix-multiply scheduler.
package tile_sched_pkg;

  localparam int unsigned TILE_DIM   = 4;
  localparam int unsigned TILE_ELEMS = TILE_DIM * TILE_DIM;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned INSTR_W    = 5;
  localparam int unsigned MEM_ADDR_W = 6;
  localparam int unsigned DIM_W      = 4;

  localparam logic [INSTR_W-1:0] INSTR_MAC_CLR = 5'd1;
  localparam logic [INSTR_W-1:0] INSTR_MAC_ACC = 5'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_START,
    ST_WAIT,
    ST_DRAIN,
    ST_NEXT
  } state_t;

  // Latched job dimensions, in tiles.
  typedef struct packed {
    logic [DIM_W-1:0] m;
    logic [DIM_W-1:0] k;
    logic [DIM_W-1:0] n;
  } dims_t;

  // Global row/column index from a tile index and an in-tile offset.
  function automatic logic [5:0] glob_idx(input logic [DIM_W-1:0] tile, input logic [1:0] sub);
    return {tile, sub};
  endfunction

endpackage

// File: rtl/tile_addr_gen.sv
// Row-major word address of element (r,c) of a 4x4 tile inside a larger matrix.
module tile_addr_gen #(
  parameter int unsigned ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        tile_row,
  input  logic [3:0]        tile_col,
  input  logic [1:0]        r,
  input  logic [1:0]        c,
  input  logic [3:0]        stride_tiles,
  output logic [ADDR_W-1:0] addr_c
);

  localparam int unsigned PROD_W = 12;

  logic [5:0]        row;
  logic [5:0]        col;
  logic [5:0]        stride_words;
  logic [PROD_W-1:0] row_off;

  // Unsigned arithmetic, wrapping silently at ADDR_W.
  always_comb begin
    row          = {tile_row, r};
    col          = {tile_col, c};
    stride_words = {stride_tiles, 2'b00};
    row_off      = PROD_W'(row) * PROD_W'(stride_words);
    addr_c       = base + ADDR_W'(row_off) + ADDR_W'(col);
  end

endmodule

// File: rtl/tile_scheduler.sv
// Sequences tile loads, array starts and result drains for a tiled C = A x B.
module tile_scheduler
  import tile_sched_pkg::*;
#(
  parameter int unsigned       ADDR_W = 16,
  parameter logic [ADDR_W-1:0] A_BASE = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0] B_BASE = ADDR_W'(16'h4000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DIM_W-1:0]      cfg_m_tiles,
  input  logic [DIM_W-1:0]      cfg_k_tiles,
  input  logic [DIM_W-1:0]      cfg_n_tiles,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic                  rd_valid,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  enA,
  output logic                  enB,
  output logic [MEM_ADDR_W-1:0] addrA,
  output logic [MEM_ADDR_W-1:0] addrB,
  output logic [DATA_W-1:0]     data_A,
  output logic [DATA_W-1:0]     data_B,
  output logic                  ap_start,
  output logic [INSTR_W-1:0]    instruction,
  output logic                  stop,
  input  logic                  array_done,
  input  logic [255:0]          res_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_W-1:0]     res_data,
  output logic [ADDR_W-1:0]     res_row,
  output logic [ADDR_W-1:0]     res_col,
  output logic                  busy,
  output logic                  all_done,
  input  logic                  abort,
  output logic                  cfg_err
);

  state_t state_q, state_d;
  dims_t  dims_q;
  logic [DIM_W-1:0] mi_q, ni_q, ki_q, mi_d, ni_d, ki_d;
  logic [3:0] e_q, e_d, e_inc;
  logic cap_cfg, cap_res;
  logic [DATA_W-1:0] res_buf [TILE_ELEMS];

  logic                  cfg_ready_d, rd_req_d, en_a_d, en_b_d, ap_start_d, stop_d;
  logic                  res_valid_d, busy_d, all_done_d, cfg_err_d;
  logic [ADDR_W-1:0]     rd_addr_d, res_row_d, res_col_d;
  logic [MEM_ADDR_W-1:0] addr_a_d, addr_b_d;
  logic [DATA_W-1:0]     data_a_d, data_b_d, res_data_d;
  logic [INSTR_W-1:0]    instr_d;

  logic [ADDR_W-1:0] ag_base, ag_addr_c;
  logic [3:0]        ag_row, ag_col, ag_stride;

  assign e_inc = e_q + 4'd1;

  // Single address generator shared between the A and B fetch phases.
  always_comb begin
    if (state_q == ST_LOAD_B) begin
      ag_base   = B_BASE;
      ag_row    = ki_q;
      ag_col    = ni_q;
      ag_stride = dims_q.n;
    end else begin
      ag_base   = A_BASE;
      ag_row    = mi_q;
      ag_col    = ki_q;
      ag_stride = dims_q.k;
    end
  end

  tile_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .base         (ag_base),
    .tile_row     (ag_row),
    .tile_col     (ag_col),
    .r            (e_q[3:2]),
    .c            (e_q[1:0]),
    .stride_tiles (ag_stride),
    .addr_c       (ag_addr_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state, counter updates and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    mi_d        = mi_q;
    ni_d        = ni_q;
    ki_d        = ki_q;
    e_d         = e_q;
    cap_cfg     = 1'b0;
    cap_res     = 1'b0;
    rd_req_d    = rd_req;
    rd_addr_d   = rd_addr;
    en_a_d      = 1'b0;
    en_b_d      = 1'b0;
    addr_a_d    = addrA;
    addr_b_d    = addrB;
    data_a_d    = data_A;
    data_b_d    = data_B;
    ap_start_d  = 1'b0;
    instr_d     = instruction;
    stop_d      = 1'b0;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_row_d   = res_row;
    res_col_d   = res_col;
    all_done_d  = 1'b0;
    cfg_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready) begin
          cap_cfg = 1'b1;
          if (cfg_m_tiles == '0 || cfg_k_tiles == '0 || cfg_n_tiles == '0) begin
            cfg_err_d = 1'b1;
          end else begin
            mi_d    = '0;
            ni_d    = '0;
            ki_d    = '0;
            e_d     = '0;
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        // Every read gets one idle cycle to present the address of the new element.
        if (!rd_req) begin
          rd_req_d  = 1'b1;
          rd_addr_d = ag_addr_c;
        end else if (rd_valid) begin
          rd_req_d = 1'b0;
          if (state_q == ST_LOAD_A) begin
            en_a_d   = 1'b1;
            addr_a_d = MEM_ADDR_W'(e_q);
            data_a_d = rd_data;
          end else begin
            en_b_d   = 1'b1;
            addr_b_d = MEM_ADDR_W'(e_q);
            data_b_d = rd_data;
          end
          e_d = e_inc;
          if (e_q == 4'd15) state_d = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_START;
        end
      end
      ST_START: begin
        ap_start_d = 1'b1;
        instr_d    = (ki_q == '0) ? INSTR_MAC_CLR : INSTR_MAC_ACC;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // A done level left over from the previous tile is ignored while ap_start is out.
        if (array_done && !ap_start) begin
          instr_d = '0;
          e_d     = '0;
          if (ki_q == dims_q.k - 4'd1) begin
            cap_res     = 1'b1;
            res_valid_d = 1'b1;
            res_data_d  = res_in[DATA_W-1:0];
            res_row_d   = ADDR_W'(glob_idx(mi_q, 2'b00));
            res_col_d   = ADDR_W'(glob_idx(ni_q, 2'b00));
            state_d     = ST_DRAIN;
          end else begin
            ki_d    = ki_q + 4'd1;
            state_d = ST_LOAD_A;
          end
        end
      end
      ST_DRAIN: begin
        if (res_valid && res_ready) begin
          if (e_q == 4'd15) begin
            res_valid_d = 1'b0;
            e_d         = '0;
            state_d     = ST_NEXT;
          end else begin
            e_d        = e_inc;
            res_data_d = res_buf[e_inc];
            res_row_d  = ADDR_W'(glob_idx(mi_q, e_inc[3:2]));
            res_col_d  = ADDR_W'(glob_idx(ni_q, e_inc[1:0]));
          end
        end
      end
      ST_NEXT: begin
        ki_d = '0;
        e_d  = '0;
        if (ni_q == dims_q.n - 4'd1) begin
          ni_d = '0;
          if (mi_q == dims_q.m - 4'd1) begin
            mi_d       = '0;
            all_done_d = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            mi_d    = mi_q + 4'd1;
            state_d = ST_LOAD_A;
          end
        end else begin
          ni_d    = ni_q + 4'd1;
          state_d = ST_LOAD_A;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything outside IDLE, including a coincident array_done.
    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      stop_d      = 1'b1;
      rd_req_d    = 1'b0;
      res_valid_d = 1'b0;
      en_a_d      = 1'b0;
      en_b_d      = 1'b0;
      ap_start_d  = 1'b0;
      instr_d     = '0;
      all_done_d  = 1'b0;
      cap_res     = 1'b0;
    end
    cfg_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // Counters, latched configuration and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dims_q      <= '0;
      mi_q        <= '0;
      ni_q        <= '0;
      ki_q        <= '0;
      e_q         <= '0;
      cfg_ready   <= 1'b0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      enA         <= 1'b0;
      enB         <= 1'b0;
      addrA       <= '0;
      addrB       <= '0;
      data_A      <= '0;
      data_B      <= '0;
      ap_start    <= 1'b0;
      instruction <= '0;
      stop        <= 1'b0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_row     <= '0;
      res_col     <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (cap_cfg) dims_q <= '{m: cfg_m_tiles, k: cfg_k_tiles, n: cfg_n_tiles};
      mi_q        <= mi_d;
      ni_q        <= ni_d;
      ki_q        <= ki_d;
      e_q         <= e_d;
      cfg_ready   <= cfg_ready_d;
      rd_req      <= rd_req_d;
      rd_addr     <= rd_addr_d;
      enA         <= en_a_d;
      enB         <= en_b_d;
      addrA       <= addr_a_d;
      addrB       <= addr_b_d;
      data_A      <= data_a_d;
      data_B      <= data_b_d;
      ap_start    <= ap_start_d;
      instruction <= instr_d;
      stop        <= stop_d;
      res_valid   <= res_valid_d;
      res_data    <= res_data_d;
      res_row     <= res_row_d;
      res_col     <= res_col_d;
      busy        <= busy_d;
      all_done    <= all_done_d;
      cfg_err     <= cfg_err_d;
    end
  end

  // Result tile snapshot taken when the last accumulation completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TILE_ELEMS; i++) res_buf[i] <= '0;
    end else if (cap_res) begin
      for (int i = 0; i < TILE_ELEMS; i++) res_buf[i] <= res_in[DATA_W*i +: DATA_W];
    end
  end

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: memory and array stubs, queued expectations.
module tb_tile_scheduler;

  localparam int unsigned ADDR_W = 16;
  localparam int A_BASE = 'h0000;
  localparam int B_BASE = 'h4000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [3:0] cfg_m_tiles = '0, cfg_k_tiles = '0, cfg_n_tiles = '0;
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic enA, enB;
  logic [5:0] addrA, addrB;
  logic [15:0] data_A, data_B;
  logic ap_start;
  logic [4:0] instruction;
  logic stop;
  logic array_done = 1'b0;
  logic [255:0] res_in = '0;
  logic res_valid;
  logic res_ready = 1'b1;
  logic [15:0] res_data;
  logic [ADDR_W-1:0] res_row, res_col;
  logic busy, all_done;
  logic abort = 1'b0;
  logic cfg_err;

  tile_scheduler #(.ADDR_W(ADDR_W), .A_BASE(16'h0000), .B_BASE(16'h4000)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_m_tiles(cfg_m_tiles), .cfg_k_tiles(cfg_k_tiles), .cfg_n_tiles(cfg_n_tiles),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .enA(enA), .enB(enB), .addrA(addrA), .addrB(addrB), .data_A(data_A), .data_B(data_B),
    .ap_start(ap_start), .instruction(instruction), .stop(stop), .array_done(array_done),
    .res_in(res_in), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .busy(busy), .all_done(all_done),
    .abort(abort), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int n_done = 0, n_stop = 0, n_err = 0, n_res = 0, n_hold = 0;
  int exp_rd[$];
  logic [22:0] exp_wr[$];
  logic [4:0] exp_ins[$];
  logic [47:0] exp_res[$];
  logic [15:0] mem [int];
  logic [15:0] res_pat [16];
  int rd_lat = 0, arr_lat = 6, tile_idx = 0, stall_at = 0;
  bit chk_en = 1'b1, abort_on_done = 1'b0, stalled = 1'b0;
  logic [47:0] stall_word = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_val(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'(a) ^ 16'h5a5a;
  endfunction

  function automatic logic any_out();
    return |{cfg_ready, rd_req, rd_addr, enA, enB, addrA, addrB, data_A, data_B, ap_start,
             instruction, stop, res_valid, res_data, res_row, res_col, busy, all_done, cfg_err};
  endfunction

  // Expected 16 reads and memory writes of one tile at (row0, col0) with a row stride in words.
  task automatic push_tile(input int base, input int row0, input int col0, input int stride, input bit is_b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        int a;
        a = base + (row0 + r) * stride + col0 + c;
        exp_rd.push_back(a);
        exp_wr.push_back({is_b, 6'(r * 4 + c), mem_val(a)});
      end
  endtask

  task automatic push_res(input int offset, input int row0, input int col0);
    for (int e = 0; e < 16; e++)
      exp_res.push_back({16'(int'(res_pat[e]) + offset), 16'(row0 + e / 4), 16'(col0 + e % 4)});
  endtask

  // Read source: answers a held request after rd_lat cycles with a one-cycle rd_valid.
  always begin
    @(negedge clk);
    rd_valid = 1'b0;
    if (rd_req) begin
      repeat (rd_lat) @(negedge clk);
      rd_data  = mem_val(int'(rd_addr));
      rd_valid = 1'b1;
    end
  end

  // Array stub: done drops on start, rises after arr_lat cycles with a tile-tagged result.
  always begin
    @(negedge clk);
    if (ap_start) begin
      array_done = 1'b0;
      repeat (arr_lat) @(negedge clk);
      for (int i = 0; i < 16; i++) res_in[16*i +: 16] = res_pat[i] + 16'(tile_idx * 256);
      tile_idx++;
      array_done = 1'b1;
      if (abort_on_done) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  always begin
    @(negedge clk);
    #1;
    if (all_done) n_done++;
    if (cfg_err) n_err++;
    if (stop) begin
      n_stop++;
      check("busy_at_stop", 64'(busy), 64'd0);
    end
    if (chk_en) begin
      if (rd_req && rd_valid) begin
        check("rd_pending", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) check("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
      end
      if (enA || enB) begin
        check("wr_pending", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0)
          check("mem_write", enA ? 64'({1'b0, addrA, data_A}) : 64'({1'b1, addrB, data_B}),
                64'(exp_wr.pop_front()));
      end
      if (ap_start) begin
        check("start_pending", 64'(exp_ins.size() != 0), 64'd1);
        if (exp_ins.size() != 0) check("instruction", 64'(instruction), 64'(exp_ins.pop_front()));
      end
      if (res_valid) begin
        if (stalled) begin
          n_hold++;
          check("res_hold", 64'({res_data, res_row, res_col}), 64'(stall_word));
        end
        if (res_ready) begin
          stalled = 1'b0;
          n_res++;
          check("res_pending", 64'(exp_res.size() != 0), 64'd1);
          if (exp_res.size() != 0) check("res_word", 64'({res_data, res_row, res_col}), 64'(exp_res.pop_front()));
        end else begin
          stalled    = 1'b1;
          stall_word = {res_data, res_row, res_col};
        end
      end
    end
  end

  task automatic run_cfg(input logic [3:0] m, input logic [3:0] k, input logic [3:0] n);
    @(negedge clk);
    for (int i = 0; i < 100 && !cfg_ready; i++) @(negedge clk);
    cfg_m_tiles = m;
    cfg_k_tiles = k;
    cfg_n_tiles = n;
    cfg_valid   = 1'b1;
    @(negedge clk);
    cfg_valid   = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    for (int i = 0; i < 5000 && n_done < target; i++) @(negedge clk);
    @(negedge clk);
    #2;
    check({name, "_all_done"}, 64'(n_done), 64'(target));
    check({name, "_queues_empty"},
          64'(exp_rd.size() + exp_wr.size() + exp_ins.size() + exp_res.size()), 64'd0);
  endtask

  initial begin
    int s0, r0, e0;
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", 64'(any_out()), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_cfg_ready", 64'(cfg_ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);

    // 1x1x1 tile, identity A, B = 1..16, zero-latency reads.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        mem[A_BASE + r * 4 + c] = (r == c) ? 16'd1 : 16'd0;
        mem[B_BASE + r * 4 + c] = 16'(r * 4 + c + 1);
        res_pat[r * 4 + c]      = 16'(r * 4 + c + 1);
      end
    tile_idx = 0;
    push_tile(A_BASE, 0, 0, 4, 1'b0);
    push_tile(B_BASE, 0, 0, 4, 1'b1);
    exp_ins.push_back(5'd1);
    push_res(0, 0, 0);
    run_cfg(4'd1, 4'd1, 4'd1);
    wait_done(1, "t1_identity");

    // M=1, K=2, N=1 with a three-cycle read latency; only the second result tile drains.
    mem.delete();
    rd_lat = 3;
    tile_idx = 0;
    for (int e = 0; e < 16; e++) res_pat[e] = 16'(e * 3 + 5);
    r0 = n_res;
    push_tile(A_BASE, 0, 0, 8, 1'b0);
    push_tile(B_BASE, 0, 0, 4, 1'b1);
    push_tile(A_BASE, 0, 4, 8, 1'b0);
    push_tile(B_BASE, 4, 0, 4, 1'b1);
    exp_ins.push_back(5'd1);
    exp_ins.push_back(5'd2);
    push_res('h100, 0, 0);
    run_cfg(4'd1, 4'd2, 4'd1);
    wait_done(2, "t2_k2");
    check("t2_single_drain", 64'(n_res - r0), 64'd16);

    // M=2, N=2, K=1: drain order (0,0),(0,1),(1,0),(1,1), with a 10-cycle sink stall.
    rd_lat = 0;
    tile_idx = 0;
    push_tile(A_BASE, 0, 0, 4, 1'b0); push_tile(B_BASE, 0, 0, 8, 1'b1); exp_ins.push_back(5'd1); push_res('h000, 0, 0);
    push_tile(A_BASE, 0, 0, 4, 1'b0); push_tile(B_BASE, 0, 4, 8, 1'b1); exp_ins.push_back(5'd1); push_res('h100, 0, 4);
    push_tile(A_BASE, 4, 0, 4, 1'b0); push_tile(B_BASE, 0, 0, 8, 1'b1); exp_ins.push_back(5'd1); push_res('h200, 4, 0);
    push_tile(A_BASE, 4, 0, 4, 1'b0); push_tile(B_BASE, 0, 4, 8, 1'b1); exp_ins.push_back(5'd1); push_res('h300, 4, 4);
    stall_at = n_res + 20;
    n_hold = 0;
    fork
      begin
        for (int i = 0; i < 4000 && n_res < stall_at; i++) @(negedge clk);
        res_ready = 1'b0;
        repeat (10) @(negedge clk);
        res_ready = 1'b1;
      end
    join_none
    run_cfg(4'd2, 4'd1, 4'd2);
    wait_done(3, "t3_2x2");
    check("t3_stall_held", 64'(n_hold >= 9), 64'd1);

    // Abort coincident with array_done: one stop, no drain, no all_done.
    tile_idx = 0;
    abort_on_done = 1'b1;
    s0 = n_stop;
    r0 = n_res;
    push_tile(A_BASE, 0, 0, 4, 1'b0);
    push_tile(B_BASE, 0, 0, 4, 1'b1);
    exp_ins.push_back(5'd1);
    run_cfg(4'd1, 4'd1, 4'd1);
    for (int i = 0; i < 3000 && n_stop == s0; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    abort_on_done = 1'b0;
    check("abort_stop_once", 64'(n_stop - s0), 64'd1);
    check("abort_no_all_done", 64'(n_done), 64'd3);
    check("abort_no_results", 64'(n_res - r0), 64'd0);
    check("abort_busy_low", 64'(busy), 64'd0);
    check("abort_queues_empty", 64'(exp_rd.size() + exp_wr.size() + exp_ins.size() + exp_res.size()), 64'd0);

    // A fresh job is accepted after the abort.
    tile_idx = 0;
    push_tile(A_BASE, 0, 0, 4, 1'b0);
    push_tile(B_BASE, 0, 0, 4, 1'b1);
    exp_ins.push_back(5'd1);
    push_res(0, 0, 0);
    run_cfg(4'd1, 4'd1, 4'd1);
    wait_done(4, "t5_after_abort");

    // Zero K dimension is rejected.
    e0 = n_err;
    run_cfg(4'd1, 4'd0, 4'd1);
    #1;
    check("zero_dim_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("zero_dim_cfg_err", 64'(n_err - e0), 64'd1);
    check("zero_dim_busy_after", 64'(busy), 64'd0);
    check("zero_dim_cfg_ready", 64'(cfg_ready), 64'd1);

    // Asynchronous reset in the middle of LOAD_B.
    chk_en = 1'b0;
    run_cfg(4'd1, 4'd1, 4'd1);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 1000 && !seen; i++) begin
        @(negedge clk);
        seen = enB;
      end
      check("reached_load_b", 64'(seen), 64'd1);
    end
    rst = 1'b0;
    #1;
    check("async_reset_outputs_zero", 64'(any_out()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_rd.delete(); exp_wr.delete(); exp_ins.delete(); exp_res.delete();
    stalled = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'(cfg_ready), 64'd1);
    check("post_reset_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
